// File: rtl/keynsham_irq_defs.sv
// rtl/keynsham_irq_defs.sv - shared register indices and widths for the interrupt controller
package keynsham_irq_defs;

  localparam int IRQ_NUM_W = 5;
  localparam int BUS_W     = 32;

  typedef enum logic [1:0] {
    REG_STATUS = 2'd0,
    REG_ENABLE = 2'd1,
    REG_RAW    = 2'd2,
    REG_CLEAR  = 2'd3
  } reg_sel_e;

  // Register bits at or above the source count are tied to zero.
  function automatic logic [BUS_W-1:0] irq_mask(input int n);
    if (n >= BUS_W) return {BUS_W{1'b1}};
    return (32'd1 << n) - 32'd1;
  endfunction

endpackage

// File: rtl/keynsham_irq_if.sv
// rtl/keynsham_irq_if.sv - register bus between address decoder/CPU and the interrupt controller
interface keynsham_irq_if;
  import keynsham_irq_defs::*;

  logic             bus_access;
  logic             irq_cs;
  logic [1:0]       reg_sel;
  logic [BUS_W-1:0] bus_wr_val;
  logic             bus_wr_en;
  logic [3:0]       bus_bytesel;
  logic             bus_error;
  logic             bus_ack;
  logic [BUS_W-1:0] bus_data;

  modport master (
    output bus_access, irq_cs, reg_sel, bus_wr_val, bus_wr_en, bus_bytesel,
    input  bus_error, bus_ack, bus_data
  );

  modport slave (
    input  bus_access, irq_cs, reg_sel, bus_wr_val, bus_wr_en, bus_bytesel,
    output bus_error, bus_ack, bus_data
  );

endinterface

// File: rtl/keynsham_irq_prio.sv
// rtl/keynsham_irq_prio.sv - fixed-priority encoder, bit 0 wins
module keynsham_irq_prio
  import keynsham_irq_defs::*;
#(
  parameter int NR_IRQS = 32
) (
  input  logic [NR_IRQS-1:0]   vec,
  output logic [IRQ_NUM_W-1:0] idx,
  output logic                 valid
);

  // Scan downward so the last hit, the lowest set index, is the one kept.
  always_comb begin
    idx   = '0;
    valid = 1'b0;
    for (int i = NR_IRQS - 1; i >= 0; i--) begin
      if (vec[i]) begin
        idx   = IRQ_NUM_W'(i);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/keynsham_irq.sv
// rtl/keynsham_irq.sv - edge-latching interrupt controller with enable mask and priority index
module keynsham_irq
  import keynsham_irq_defs::*;
#(
  parameter int NR_IRQS = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  keynsham_irq_if.slave        bus,
  input  logic [NR_IRQS-1:0]   irq_in,
  output logic                 irq_req,
  output logic [IRQ_NUM_W-1:0] irq_num
);

  localparam logic [BUS_W-1:0] MASK = irq_mask(NR_IRQS);

  logic [BUS_W-1:0]     pending, pending_next;
  logic [BUS_W-1:0]     enable, enable_next;
  logic [BUS_W-1:0]     prev_in, irq_ext, rise, active;
  logic                 access, wr;
  reg_sel_e             sel;
  logic [IRQ_NUM_W-1:0] prio_idx;
  logic                 prio_valid;

  assign sel    = reg_sel_e'(bus.reg_sel);
  assign access = bus.bus_access && bus.irq_cs;
  assign wr     = access && bus.bus_wr_en;

  always_comb begin
    irq_ext = '0;
    irq_ext[NR_IRQS-1:0] = irq_in;
  end

  assign rise   = irq_ext & ~prev_in;
  assign active = pending & enable;

  // Clear is applied before set so a coincident edge or software trigger wins.
  always_comb begin
    pending_next = pending;
    if (wr && sel == REG_CLEAR) pending_next = pending_next & ~bus.bus_wr_val;
    if (wr && sel == REG_RAW)   pending_next = pending_next | bus.bus_wr_val;
    pending_next = (pending_next | rise) & MASK;
  end

  always_comb begin
    enable_next = enable;
    for (int b = 0; b < 4; b++) begin
      if (wr && sel == REG_ENABLE && bus.bus_bytesel[b])
        enable_next[b*8 +: 8] = bus.bus_wr_val[b*8 +: 8];
    end
    enable_next = enable_next & MASK;
  end

  always_comb begin
    bus.bus_data = '0;
    case (sel)
      REG_STATUS: bus.bus_data = active;
      REG_ENABLE: bus.bus_data = enable;
      REG_RAW:    bus.bus_data = pending;
      REG_CLEAR:  bus.bus_data = '0;
      default:    bus.bus_data = '0;
    endcase
  end

  keynsham_irq_prio #(.NR_IRQS(NR_IRQS)) u_prio (
    .vec   (active[NR_IRQS-1:0]),
    .idx   (prio_idx),
    .valid (prio_valid)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending       <= '0;
      enable        <= '0;
      prev_in       <= '0;
      bus.bus_ack   <= 1'b0;
      bus.bus_error <= 1'b0;
      irq_req       <= 1'b0;
      irq_num       <= '0;
    end else begin
      pending       <= pending_next;
      enable        <= enable_next;
      prev_in       <= irq_ext;
      bus.bus_ack   <= access;
      bus.bus_error <= wr && sel == REG_STATUS;
      irq_req       <= prio_valid;
      irq_num       <= prio_idx;
    end
  end

endmodule

// File: tb/tb_keynsham_irq.sv
// tb/tb_keynsham_irq.sv - vector table plus hand sequences with an ack/error scoreboard
module tb_keynsham_irq;
  import keynsham_irq_defs::*;

  localparam int NR = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [NR-1:0] irq_in;
  logic          irq_req;
  logic [4:0]    irq_num;

  keynsham_irq_if bus_if();

  keynsham_irq #(.NR_IRQS(NR)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus_if.slave),
    .irq_in  (irq_in),
    .irq_req (irq_req),
    .irq_num (irq_num)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  typedef struct {
    logic err;
    int   due;
  } ack_t;
  ack_t ack_q[$];
  ack_t mon_item;

  typedef struct {
    logic        wr;
    logic [1:0]  sel;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] exp_rd;
    logic        exp_req;
    logic [4:0]  exp_num;
  } vec_t;
  vec_t tbl[$];

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Every acked access was queued with the cycle its ack is due.
  always @(negedge clk) begin
    if (ack_q.size() > 0 && ack_q[0].due == cyc) begin
      mon_item = ack_q.pop_front();
      check("bus_ack", {31'd0, bus_if.bus_ack}, 32'd1);
      check("bus_error", {31'd0, bus_if.bus_error}, {31'd0, mon_item.err});
    end else if (bus_if.bus_ack === 1'b1 || bus_if.bus_error === 1'b1) begin
      check("spurious ack/error", {30'd0, bus_if.bus_ack, bus_if.bus_error}, 32'd0);
    end
  end

  task automatic bus_idle();
    bus_if.bus_access  = 1'b0;
    bus_if.irq_cs      = 1'b0;
    bus_if.reg_sel     = 2'd0;
    bus_if.bus_wr_val  = 32'd0;
    bus_if.bus_wr_en   = 1'b0;
    bus_if.bus_bytesel = 4'd0;
  endtask

  // Called just after a rising edge; returns just after the next one.
  task automatic bus_op(input logic wr, input logic cs, input logic [1:0] sel,
                        input logic [31:0] wdata, input logic [3:0] be,
                        input logic chk_rd, input logic [31:0] exp_rd, input string name);
    bus_if.bus_access  = 1'b1;
    bus_if.irq_cs      = cs;
    bus_if.reg_sel     = sel;
    bus_if.bus_wr_val  = wdata;
    bus_if.bus_wr_en   = wr;
    bus_if.bus_bytesel = be;
    if (cs) ack_q.push_back('{err: (wr && sel == REG_STATUS), due: cyc + 1});
    @(negedge clk);
    if (chk_rd) check(name, bus_if.bus_data, exp_rd);
    @(posedge clk);
    #1;
    bus_idle();
  endtask

  task automatic wr_reg(input logic [1:0] sel, input logic [31:0] d, input logic [3:0] be);
    bus_op(1'b1, 1'b1, sel, d, be, 1'b0, 32'd0, "");
  endtask

  task automatic rd_reg(input logic [1:0] sel, input logic [31:0] exp, input string name);
    bus_op(1'b0, 1'b1, sel, 32'hFFFF_FFFF, 4'hF, 1'b1, exp, name);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1);
  end

  initial begin
    bus_idle();
    irq_in = '0;

    tbl.push_back('{1'b1, REG_ENABLE, 32'hAABBCCDD, 4'b0101, 32'h0,        1'b0, 5'd0});
    tbl.push_back('{1'b0, REG_ENABLE, 32'h0,        4'hF,    32'h00BB00DD, 1'b0, 5'd0});
    tbl.push_back('{1'b1, REG_ENABLE, 32'h0,        4'hF,    32'h0,        1'b0, 5'd0});
    tbl.push_back('{1'b1, REG_RAW,    32'h30,       4'h0,    32'h0,        1'b0, 5'd0});
    tbl.push_back('{1'b0, REG_RAW,    32'h0,        4'hF,    32'h30,       1'b0, 5'd0});
    tbl.push_back('{1'b0, REG_STATUS, 32'h0,        4'hF,    32'h0,        1'b0, 5'd0});
    tbl.push_back('{1'b1, REG_ENABLE, 32'h20,       4'hF,    32'h0,        1'b1, 5'd5});
    tbl.push_back('{1'b1, REG_ENABLE, 32'h30,       4'b0001, 32'h0,        1'b1, 5'd4});
    tbl.push_back('{1'b0, REG_STATUS, 32'h0,        4'hF,    32'h30,       1'b1, 5'd4});
    tbl.push_back('{1'b1, REG_CLEAR,  32'h10,       4'h0,    32'h0,        1'b1, 5'd5});
    tbl.push_back('{1'b0, REG_RAW,    32'h0,        4'hF,    32'h20,       1'b1, 5'd5});
    tbl.push_back('{1'b1, REG_STATUS, 32'hFFFFFFFF, 4'hF,    32'h0,        1'b1, 5'd5});
    tbl.push_back('{1'b0, REG_STATUS, 32'h0,        4'hF,    32'h20,       1'b1, 5'd5});
    tbl.push_back('{1'b0, REG_CLEAR,  32'h0,        4'hF,    32'h0,        1'b1, 5'd5});
    tbl.push_back('{1'b1, REG_CLEAR,  32'h20,       4'h0,    32'h0,        1'b0, 5'd0});
    tbl.push_back('{1'b1, REG_RAW,    32'h80000001, 4'h0,    32'h0,        1'b0, 5'd0});
    tbl.push_back('{1'b1, REG_ENABLE, 32'hFFFFFFFF, 4'b1000, 32'h0,        1'b1, 5'd31});
    tbl.push_back('{1'b0, REG_STATUS, 32'h0,        4'hF,    32'h80000000, 1'b1, 5'd31});
    tbl.push_back('{1'b1, REG_ENABLE, 32'hFFFFFFFF, 4'hF,    32'h0,        1'b1, 5'd0});
    tbl.push_back('{1'b1, REG_CLEAR,  32'hFFFFFFFF, 4'h0,    32'h0,        1'b0, 5'd0});
    tbl.push_back('{1'b1, REG_ENABLE, 32'h0,        4'hF,    32'h0,        1'b0, 5'd0});

    repeat (2) @(posedge clk);
    #1;
    bus_if.reg_sel = REG_RAW;
    #1;
    check("reset bus_ack", {31'd0, bus_if.bus_ack}, 32'd0);
    check("reset bus_error", {31'd0, bus_if.bus_error}, 32'd0);
    check("reset irq_req", {31'd0, irq_req}, 32'd0);
    check("reset irq_num", {27'd0, irq_num}, 32'd0);
    check("reset pending", bus_if.bus_data, 32'd0);
    bus_idle();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    rd_reg(REG_ENABLE, 32'h0, "reset enable");

    for (int i = 0; i < tbl.size(); i++) begin
      bus_op(tbl[i].wr, 1'b1, tbl[i].sel, tbl[i].wdata, tbl[i].be,
             !tbl[i].wr, tbl[i].exp_rd, $sformatf("vec%0d read", i));
      @(posedge clk);
      #1;
      check($sformatf("vec%0d irq_req", i), {31'd0, irq_req}, {31'd0, tbl[i].exp_req});
      check($sformatf("vec%0d irq_num", i), {27'd0, irq_num}, {27'd0, tbl[i].exp_num});
    end

    // Timer edge on bit 0: pending first, request one cycle later; held level does not re-pend.
    wr_reg(REG_ENABLE, 32'h1, 4'hF);
    irq_in[0] = 1'b1;
    @(posedge clk);
    #1;
    check("edge irq_req not yet", {31'd0, irq_req}, 32'd0);
    rd_reg(REG_RAW, 32'h1, "edge raw");
    check("edge irq_req", {31'd0, irq_req}, 32'd1);
    check("edge irq_num", {27'd0, irq_num}, 32'd0);
    wr_reg(REG_CLEAR, 32'h1, 4'h0);
    rd_reg(REG_RAW, 32'h0, "held level no re-pend");
    irq_in[0] = 1'b0;
    wr_reg(REG_ENABLE, 32'h0, 4'hF);

    // Edge coinciding with CLEAR of the same bit keeps it pending; STATUS write errors.
    wr_reg(REG_RAW, 32'h8, 4'h0);
    irq_in[3] = 1'b1;
    wr_reg(REG_CLEAR, 32'h8, 4'h0);
    rd_reg(REG_RAW, 32'h8, "edge beats clear");
    wr_reg(REG_STATUS, 32'hFF, 4'hF);
    rd_reg(REG_RAW, 32'h8, "status write no effect");
    irq_in[3] = 1'b0;
    wr_reg(REG_CLEAR, 32'hFFFFFFFF, 4'h0);
    rd_reg(REG_RAW, 32'h0, "clear all");

    // Deselected write and a read with data on the bus leave state alone.
    bus_op(1'b1, 1'b0, REG_ENABLE, 32'hFFFFFFFF, 4'hF, 1'b0, 32'd0, "");
    rd_reg(REG_ENABLE, 32'h0, "no cs write ignored");
    rd_reg(REG_RAW, 32'h0, "read no side effect");

    // Reset mid-access clears everything at once and swallows the access.
    wr_reg(REG_RAW, 32'h80000000, 4'h0);
    wr_reg(REG_ENABLE, 32'hFFFFFFFF, 4'hF);
    @(posedge clk);
    #1;
    check("pre-reset irq_req", {31'd0, irq_req}, 32'd1);
    check("pre-reset irq_num", {27'd0, irq_num}, 32'd31);
    bus_if.bus_access  = 1'b1;
    bus_if.irq_cs      = 1'b1;
    bus_if.bus_wr_en   = 1'b1;
    bus_if.reg_sel     = REG_ENABLE;
    bus_if.bus_wr_val  = 32'h0000FFFF;
    bus_if.bus_bytesel = 4'hF;
    #2;
    rst_n = 1'b0;
    bus_if.reg_sel = REG_RAW;
    #1;
    check("async irq_req", {31'd0, irq_req}, 32'd0);
    check("async irq_num", {27'd0, irq_num}, 32'd0);
    check("async pending", bus_if.bus_data, 32'd0);
    check("async bus_ack", {31'd0, bus_if.bus_ack}, 32'd0);
    bus_if.reg_sel = REG_ENABLE;
    irq_in[1] = 1'b1;
    @(posedge clk);
    #1;
    bus_idle();
    ack_q.delete();
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    rd_reg(REG_RAW, 32'h2, "high at release pends");
    rd_reg(REG_ENABLE, 32'h0, "write during reset ignored");
    irq_in[1] = 1'b0;
    wr_reg(REG_CLEAR, 32'hFFFFFFFF, 4'h0);

    repeat (3) @(posedge clk);
    #1;
    check("ack queue drained", ack_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/keynsham_irq.md
KEYNSHAM_IRQ -- requirements
Module: keynsham_irq

Interface
REQ-001 Parameter NR_IRQS, default 32, number of interrupt sources (legal range 1..32); unused upper bits of every 32-bit register read 0 and ignore writes.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low; state cleared immediately on rst_n=0.
REQ-004 bus_access  input  1  a bus transfer is in progress this cycle.
REQ-005 irq_cs  input  1  controller selected by the address decoder.
REQ-006 reg_sel  input  2  register index: 0 STATUS, 1 ENABLE, 2 RAW, 3 CLEAR.
REQ-007 bus_wr_val  input  32  write data.
REQ-008 bus_wr_en  input  1  transfer is a write.
REQ-009 bus_bytesel  input  4  byte lane enables for writes to ENABLE.
REQ-010 irq_in  input  NR_IRQS  synchronous interrupt sources (the timer drives bit 0).
REQ-011 bus_error  output  1  registered error response.
REQ-012 bus_ack  output  1  registered acknowledge.
REQ-013 bus_data  output  32  read data.
REQ-014 irq_req  output  1  registered interrupt request to the CPU.
REQ-015 irq_num  output  5  registered index of the highest-priority active interrupt.

Function
REQ-016 Access = bus_access && irq_cs; bus_ack SHALL equal the previous cycle's access (one-cycle latency, one ack per access cycle).
REQ-017 bus_data SHALL be combinational from reg_sel: STATUS = pending & enable; ENABLE = enable; RAW = pending; CLEAR = 0.
REQ-018 Rising edge detect: pending[i] SHALL set on the cycle after irq_in[i] goes 0->1 versus its registered previous value; levels held high do not re-set a cleared bit.
REQ-019 ENABLE write SHALL update only byte lanes with bus_bytesel[n]=1; other lanes hold.
REQ-020 RAW write SHALL OR bus_wr_val into pending (software trigger), ignoring bytesel.
REQ-021 CLEAR write SHALL clear pending bits where bus_wr_val is 1 (write-1-to-clear), ignoring bytesel.
REQ-022 STATUS write SHALL have no state effect and SHALL assert bus_error together with bus_ack the following cycle; every other access gives bus_error=0.
REQ-023 Same-cycle edge and CLEAR on one bit: set wins, bit remains pending.
REQ-024 Edge and RAW write on one bit: bit set once; no counting.
REQ-025 Masking does not gate latching: disabled sources still pend; enabling later raises the request.
REQ-026 irq_req SHALL be registered |(pending & enable), visible one cycle after the pending/enable change.
REQ-027 irq_num SHALL be registered lowest index set in pending & enable (bit 0 highest priority); 0 when none active.
REQ-028 Writes SHALL be ignored when bus_wr_en=0 or irq_cs=0; reads have no side effects.

Reset
REQ-029 On rst_n=0: pending=0, enable=0, previous-input register=0, bus_ack=0, bus_error=0, irq_req=0, irq_num=0.
REQ-030 Because previous-input resets to 0, a source high at reset release SHALL pend on the first clock edge after release.
REQ-031 Reset asserted mid-access SHALL suppress that access's ack and any write effect.

Structure
REQ-032 Shared package keynsham_irq_defs SHALL hold the register index constants (STATUS, ENABLE, RAW, CLEAR) and the irq_num width.
REQ-033 Priority encoding SHALL be a sub-module keynsham_irq_prio (NR_IRQS-bit vector in, 5-bit index and valid out).

Verification
REQ-034 Pulse irq_in[0] 0->1, ENABLE=0x1 -> RAW reads 0x1, irq_req=1, irq_num=0 one cycle after pending visible.
REQ-035 Pending 0x30, ENABLE=0x20 -> irq_num=5; write ENABLE=0x30 -> irq_num=4; CLEAR 0x10 -> irq_num=5.
REQ-036 ENABLE write 0xAABBCCDD with bytesel=4'b0101 from 0 -> ENABLE reads 0x00BB00DD.
REQ-037 irq_in[3] rising edge in same cycle as CLEAR 0x8 -> RAW bit 3 still 1; write STATUS -> bus_ack=1 with bus_error=1, pending unchanged.
REQ-038 RAW write 0x80000000, ENABLE=0xFFFFFFFF, then rst_n=0 mid-cycle -> irq_req, irq_num, pending, bus_ack all 0 immediately.
